// File: rtl/button_select_ctl_pkg.sv
// Shared state encoding, default hold-off length and index-width helper
// for the menu button-group selection controller.
package button_select_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_REL = 3'd1,
    ST_ARMED    = 3'd2,
    ST_REPORT   = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_e;

  localparam int unsigned LOCK_CYCLES_DEFAULT = 1_000_000;

  // Width of a button index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_select_ctl_lockout_timer.sv
// Post-selection hold-off counter: loads LOCK_CYCLES-1, counts down and
// saturates at zero. done_o is high whenever the count is zero.
module lockout_timer
  import button_select_ctl_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic load_i,
  output logic done_o
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(LOCK_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/button_select_ctl.sv
// Arbitrates press flags from a group of on-screen buttons, hands one
// selection at a time to the game FSM and locks out presses afterwards.
module button_select_ctl
  import button_select_ctl_pkg::*;
#(
  parameter  int unsigned N_BUTTONS   = 4,
  parameter  int unsigned LOCK_CYCLES = LOCK_CYCLES_DEFAULT,
  localparam int unsigned IDX_W       = idx_width(N_BUTTONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 menu_active,
  input  logic [N_BUTTONS-1:0] button_mask,
  input  logic                 mouse_left,
  input  logic [N_BUTTONS-1:0] button_pressed,
  output logic [N_BUTTONS-1:0] button_enable,
  output logic                 sel_valid,
  output logic [IDX_W-1:0]     sel_idx,
  input  logic                 sel_ready,
  output logic                 busy
);

  // NOTE: the function's local variable is assigned with blocking '=' because
  // it is combinational scratch; it never becomes a register.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_BUTTONS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  state_e                 state_q;
  logic                   sel_valid_q;
  logic [IDX_W-1:0]       sel_idx_q;
  logic                   busy_q;
  logic [N_BUTTONS-1:0]   button_enable_q;

  logic [N_BUTTONS-1:0]   pressed_masked;
  logic                   xfer;
  logic                   timer_load;
  logic                   timer_clear;
  logic                   timer_done;

  assign pressed_masked = button_pressed & button_mask;
  assign xfer           = (state_q == ST_REPORT) && sel_valid_q && sel_ready;
  assign timer_load     = menu_active && xfer;
  assign timer_clear    = !menu_active;

  lockout_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lockout_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (timer_clear),
    .load_i  (timer_load),
    .done_o  (timer_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      sel_valid_q     <= 1'b0;
      sel_idx_q       <= '0;
      busy_q          <= 1'b0;
      button_enable_q <= '0;
    end else if (!menu_active) begin
      state_q         <= ST_IDLE;
      sel_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      button_enable_q <= '0;
    end else begin
      // With menu_active high the next state is never IDLE, so the enables
      // simply track the mask one cycle later.
      button_enable_q <= button_mask;
      case (state_q)
        ST_IDLE: state_q <= ST_WAIT_REL;
        ST_WAIT_REL: begin
          if (!mouse_left) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (pressed_masked != '0) begin
            sel_idx_q   <= lowest_set(pressed_masked);
            sel_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (xfer) begin
            sel_valid_q <= 1'b0;
            state_q     <= ST_LOCKOUT;
          end
        end
        ST_LOCKOUT: begin
          if (timer_done && !mouse_left) begin
            busy_q  <= 1'b0;
            state_q <= ST_ARMED;
          end
        end
        default: begin
          sel_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign button_enable = button_enable_q;
  assign sel_valid     = sel_valid_q;
  assign sel_idx       = sel_idx_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_button_select_ctl.sv
// Self-checking bench for button_select_ctl (N_BUTTONS=4, LOCK_CYCLES=16):
// expected selections are queued as presses are driven and popped on sel_valid.
module tb_button_select_ctl;

  localparam int unsigned N     = 4;
  localparam int unsigned LOCK  = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         menu_active;
  logic [N-1:0] button_mask;
  logic         mouse_left;
  logic [N-1:0] button_pressed;
  logic [N-1:0] button_enable;
  logic         sel_valid;
  logic [1:0]   sel_idx;
  logic         sel_ready;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  int sb[$];

  button_select_ctl #(
    .N_BUTTONS   (N),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .menu_active    (menu_active),
    .button_mask    (button_mask),
    .mouse_left     (mouse_left),
    .button_pressed (button_pressed),
    .button_enable  (button_enable),
    .sel_valid      (sel_valid),
    .sel_idx        (sel_idx),
    .sel_ready      (sel_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a selection, then compare against the scoreboard head.
  task automatic expect_sel(input string tag);
    int n;
    int exp;
    n = 0;
    while (!sel_valid && n < 20) begin
      cyc(1);
      n++;
    end
    check({tag, "_valid"}, 32'(sel_valid), 32'd1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check({tag, "_idx"}, 32'(sel_idx), 32'(exp));
    end else begin
      check({tag, "_sb_underflow"}, 32'(sel_idx), 32'hdead);
    end
  endtask

  task automatic press(input logic [N-1:0] p);
    button_pressed = p;
    cyc(1);
    button_pressed = '0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; menu_active = 1'b0; button_mask = '0; mouse_left = 1'b0;
    button_pressed = '0; sel_ready = 1'b0;
    cyc(3);
    check("rst_enable", 32'(button_enable), 32'h0);
    check("rst_valid", 32'(sel_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    cyc(2);
    check("idle_enable", 32'(button_enable), 32'h0);

    // Menu opens while the mouse is still down: enables on, no selection.
    button_mask = 4'b1111; mouse_left = 1'b1; menu_active = 1'b1;
    cyc(1);
    check("open_enable", 32'(button_enable), 32'hf);
    press(4'b0100);
    cyc(2);
    check("wait_rel_no_sel", 32'(sel_valid), 32'h0);
    check("wait_rel_busy", 32'(busy), 32'h0);
    mouse_left = 1'b0;
    cyc(1);
    sb.push_back(2);
    press(4'b0100);
    expect_sel("sel2");
    check("report_busy", 32'(busy), 32'h1);
    sel_ready = 1'b1;
    cyc(1);
    sel_ready = 1'b0;
    check("xfer1_valid", 32'(sel_valid), 32'h0);
    cyc(15);
    check("lock_last_busy", 32'(busy), 32'h1);
    cyc(1);
    check("lock_done_busy", 32'(busy), 32'h0);

    // Simultaneous presses: lowest index wins; valid held while not ready.
    sb.push_back(1);
    press(4'b1010);
    expect_sel("sel1");
    for (int i = 0; i < 10; i++) begin
      if (i == 4) button_mask = 4'b0001;
      cyc(1);
      check($sformatf("hold_valid_%0d", i), 32'(sel_valid), 32'h1);
      check($sformatf("hold_idx_%0d", i), 32'(sel_idx), 32'h1);
    end
    check("mask_chg_enable", 32'(button_enable), 32'h1);
    button_mask = 4'b1111;
    sel_ready = 1'b1;
    cyc(1);
    sel_ready = 1'b0;
    check("xfer2_valid", 32'(sel_valid), 32'h0);
    check("xfer2_busy", 32'(busy), 32'h1);

    // Lockout: presses ignored, held mouse extends past the counter.
    mouse_left = 1'b1;
    cyc(3);
    press(4'b0001);
    cyc(16);
    check("lock_hold_busy", 32'(busy), 32'h1);
    check("lock_hold_valid", 32'(sel_valid), 32'h0);
    mouse_left = 1'b0;
    cyc(1);
    check("lock_release_busy", 32'(busy), 32'h0);
    sb.push_back(3);
    press(4'b1000);
    expect_sel("sel3");
    sel_ready = 1'b1;
    cyc(1);
    sel_ready = 1'b0;
    cyc(16);
    check("lock3_done_busy", 32'(busy), 32'h0);

    // Masked-off button produces no selection and stays disabled.
    button_mask = 4'b1011;
    cyc(1);
    check("mask_enable", 32'(button_enable), 32'hb);
    press(4'b0100);
    cyc(3);
    check("masked_no_sel", 32'(sel_valid), 32'h0);

    // Press with sel_ready already high in ARMED: ready is ignored.
    sb.push_back(1);
    sel_ready = 1'b1;
    press(4'b0110);
    sel_ready = 1'b0;
    expect_sel("sel_rdy_armed");
    cyc(2);
    check("rdy_armed_still_valid", 32'(sel_valid), 32'h1);

    // menu_active drops during REPORT.
    menu_active = 1'b0;
    cyc(1);
    check("drop_valid", 32'(sel_valid), 32'h0);
    check("drop_enable", 32'(button_enable), 32'h0);
    check("drop_busy", 32'(busy), 32'h0);
    mouse_left = 1'b1; menu_active = 1'b1;
    cyc(1);
    check("reopen_enable", 32'(button_enable), 32'hb);
    press(4'b0001);
    cyc(2);
    check("reopen_wait_rel", 32'(sel_valid), 32'h0);
    mouse_left = 1'b0;
    cyc(1);
    sb.push_back(0);
    press(4'b0001);
    expect_sel("sel0");

    // Asynchronous reset in the middle of REPORT.
    #2 rst = 1'b0;
    #1;
    check("async_valid", 32'(sel_valid), 32'h0);
    check("async_enable", 32'(button_enable), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    check("async_idx", 32'(sel_idx), 32'h0);
    menu_active = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(2);
    check("post_rst_enable", 32'(button_enable), 32'h0);
    menu_active = 1'b1;
    cyc(2);
    check("post_rst_open", 32'(button_enable), 32'hb);
    sb.push_back(3);
    press(4'b1000);
    expect_sel("sel_after_rst");

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
